// File: rtl/miso_fifo_reader.sv
// Pops the miso_fifo byte stream, packs LANES bytes per word for a valid/ready
// consumer, and replays the FIFO contents by pulsing its read-pointer reset.
module miso_fifo_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int CNT_WIDTH   = 6,
  parameter int REUSE_WIDTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_clear,
  input  logic                        i_start,
  input  logic [CNT_WIDTH-1:0]        i_count,
  input  logic [REUSE_WIDTH-1:0]      i_reuse,
  input  logic [1:0]                  i_p_mode,
  input  logic                        i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]       i_pop_data,
  input  logic                        i_pop_valid,
  output logic                        o_pop_en,
  output logic                        o_r_pointer_reset,
  output logic [LANES*DATA_WIDTH-1:0] o_data,
  output logic [LANES-1:0]            o_lane_valid,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic [1:0]                  o_p_mode,
  output logic                        o_busy,
  output logic                        o_done
);
  localparam int LW = $clog2(LANES + 1);
  localparam int WW = LANES * DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_DRAIN, S_RPTR, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]   count, issued, returned, ret_cnt;
  logic [REUSE_WIDTH-1:0] reuse, pass;
  logic [LW-1:0]          lane_cnt, inflight, lane_fill, inflight_after, lane_base;
  logic [WW-1:0]          lane_buf, word_nxt;
  logic [LANES-1:0]       fill_mask;
  logic                   ret, close, out_free, move, stall, pop, zero_done, drained;

  // Occupancy is evaluated after this cycle's returning byte and any word
  // hand-off, so popping continues back-to-back across word boundaries.
  always_comb begin
    ret            = i_pop_valid && (inflight != '0);
    lane_fill      = lane_cnt + LW'(ret);
    inflight_after = inflight - LW'(ret);
    ret_cnt        = returned + CNT_WIDTH'(ret);
    close          = (lane_fill == LW'(LANES)) ||
                     ((ret_cnt == count) && (inflight_after == '0) && (lane_fill != '0));
    out_free       = !o_valid || i_ready;
    move           = close && out_free;
    stall          = close && !out_free;
    lane_base      = move ? '0 : lane_fill;
    pop            = (state == S_POP) && !i_clear && !i_fifo_empty && (issued < count) &&
                     !stall && (({1'b0, lane_base} + {1'b0, inflight_after}) < (LW+1)'(LANES));
    drained        = (inflight == '0) && (lane_cnt == '0) && !o_valid;
    word_nxt       = lane_buf;
    fill_mask      = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ret && (lane_cnt == LW'(i))) word_nxt[i*DATA_WIDTH +: DATA_WIDTH] = i_pop_data;
      fill_mask[i] = (LW'(i) < lane_fill);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    o_pop_en          = pop;
    o_r_pointer_reset = (state == S_RPTR);
    o_busy            = (state != S_IDLE);
    o_done            = (state == S_DONE) || zero_done;
    case (state)
      S_IDLE:  if (i_start && (i_count != '0)) state_nxt = S_POP;
      S_POP:   if (issued == count) state_nxt = S_DRAIN;
      S_DRAIN: if (drained) state_nxt = (pass < reuse) ? S_RPTR : S_DONE;
      S_RPTR:  state_nxt = S_POP;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_clear) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      count <= '0; reuse <= '0; pass <= '0; issued <= '0; returned <= '0;
      lane_cnt <= '0; inflight <= '0; lane_buf <= '0; zero_done <= 1'b0;
      o_data <= '0; o_lane_valid <= '0; o_last <= 1'b0; o_valid <= 1'b0; o_p_mode <= '0;
    end else if (i_clear) begin
      count <= '0; reuse <= '0; pass <= '0; issued <= '0; returned <= '0;
      lane_cnt <= '0; inflight <= '0; lane_buf <= '0; zero_done <= 1'b0;
      o_data <= '0; o_lane_valid <= '0; o_last <= 1'b0; o_valid <= 1'b0;
    end else begin
      zero_done <= (state == S_IDLE) && i_start && (i_count == '0);
      inflight  <= inflight_after + LW'(pop);
      issued    <= issued + CNT_WIDTH'(pop);
      returned  <= ret_cnt;
      if (move) begin
        lane_buf     <= '0;
        lane_cnt     <= '0;
        o_data       <= word_nxt;
        o_lane_valid <= fill_mask;
        o_last       <= (ret_cnt == count);
        o_valid      <= 1'b1;
      end else begin
        lane_buf <= word_nxt;
        lane_cnt <= lane_fill;
        if (i_ready) o_valid <= 1'b0;
      end
      case (state)
        S_IDLE: if (i_start && (i_count != '0)) begin
          count    <= i_count;
          reuse    <= i_reuse;
          o_p_mode <= i_p_mode;
          pass     <= '0;
          issued   <= '0;
          returned <= '0;
        end
        S_RPTR: begin
          pass     <= pass + REUSE_WIDTH'(1);
          issued   <= '0;
          returned <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
